// File: rtl/pipe_issue_if.sv
// pipe_issue_if: program-load, run-control and issue bus between a controller and pipe_issue.
interface pipe_issue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic [LW-1:0] prog_len;
  logic          start;
  logic          hold;
  logic [7:0]    inst;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, hold,
    input  inst, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, hold,
    output inst, busy, done
  );
endinterface

// File: rtl/pipe_issue.sv
// pipe_issue: replays a one-hot program into the pipeline, spacing load->mult and add->write with NOP bubbles.
// Optional feature macro ISSUE_STATS_EN adds the stall_cnt hazard-bubble counter port.
module pipe_issue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LOAD_GAP  = 2,
  parameter int unsigned WRITE_GAP = 2
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef ISSUE_STATS_EN
  output logic [15:0] stall_cnt,
`endif
  pipe_issue_if.slave bus
);
  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned LW         = AW + 1;
  localparam int unsigned GAP_MAX    = (LOAD_GAP > WRITE_GAP) ? LOAD_GAP : WRITE_GAP;
  localparam int unsigned GW         = $clog2(GAP_MAX + 1);
  localparam int unsigned B_NOP      = 0;
  localparam int unsigned B_LD_DATA  = 1;
  localparam int unsigned B_LD_COEFF = 2;
  localparam int unsigned B_ADD      = 3;
  localparam int unsigned B_MULT     = 4;
  localparam int unsigned B_WRITE    = 5;
  localparam logic [7:0]  NOP_W      = 8'(1 << B_NOP);
  localparam logic [7:0]  DEF_MASK   = 8'h3F;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] pc_q, pc_d;
  logic [LW-1:0] len_q, len_d;
  logic [GW-1:0] since_load_q, since_load_d;
  logic [GW-1:0] since_add_q, since_add_d;
  logic [7:0]    inst_q, inst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          zero_q, zero_d;
`ifdef ISSUE_STATS_EN
  logic [15:0]   stall_q, stall_d;
`endif

  logic [7:0] w_raw_c, w_mask_c, w_san_c;
  logic       has_load_c, has_mult_c, has_add_c, has_write_c;
  logic       start_ok_c, run_end_c, hazard_c, issue_c;

  // Candidate word decode; undefined bits dropped, empty words become NOP.
  always_comb begin
    w_raw_c     = mem_q[pc_q[AW-1:0]];
    w_mask_c    = w_raw_c & DEF_MASK;
    w_san_c     = (w_mask_c == 8'h00) ? NOP_W : w_mask_c;
    has_load_c  = w_san_c[B_LD_DATA] | w_san_c[B_LD_COEFF];
    has_mult_c  = w_san_c[B_MULT];
    has_add_c   = w_san_c[B_ADD];
    has_write_c = w_san_c[B_WRITE];
    start_ok_c  = bus.start && (state_q == S_IDLE);
    run_end_c   = (pc_q == len_q);
    hazard_c    = (has_mult_c && (since_load_q < GW'(LOAD_GAP))) ||
                  (has_write_c && (since_add_q < GW'(WRITE_GAP)));
    issue_c     = !run_end_c && !bus.hold && !hazard_c;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok_c && (bus.prog_len != '0)) state_d = S_RUN;
      S_RUN:   if (run_end_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gap counters hold "cycles since last issue"; the issuing cycle itself counts as 0.
  always_comb begin
    inst_d       = NOP_W;
    busy_d       = (state_d == S_RUN);
    done_d       = zero_q;
    zero_d       = 1'b0;
    pc_d         = pc_q;
    len_d        = len_q;
    since_load_d = (since_load_q == GW'(GAP_MAX)) ? since_load_q : since_load_q + GW'(1);
    since_add_d  = (since_add_q == GW'(GAP_MAX)) ? since_add_q : since_add_q + GW'(1);
`ifdef ISSUE_STATS_EN
    stall_d      = stall_q;
`endif
    if (start_ok_c) begin
      pc_d         = '0;
      len_d        = bus.prog_len;
      zero_d       = (bus.prog_len == '0);
      since_load_d = GW'(GAP_MAX);
      since_add_d  = GW'(GAP_MAX);
`ifdef ISSUE_STATS_EN
      stall_d      = 16'd0;
`endif
    end else if (state_q == S_RUN) begin
      if (run_end_c) begin
        done_d = 1'b1;
      end else if (issue_c) begin
        inst_d = w_san_c;
        pc_d   = pc_q + LW'(1);
        if (has_load_c) since_load_d = GW'(1);
        if (has_add_c)  since_add_d  = GW'(1);
      end
`ifdef ISSUE_STATS_EN
      else if (!bus.hold && hazard_c) begin
        stall_d = stall_q + 16'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q         <= '0;
      len_q        <= '0;
      since_load_q <= GW'(GAP_MAX);
      since_add_q  <= GW'(GAP_MAX);
      inst_q       <= NOP_W;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      zero_q       <= 1'b0;
`ifdef ISSUE_STATS_EN
      stall_q      <= 16'd0;
`endif
    end else begin
      pc_q         <= pc_d;
      len_q        <= len_d;
      since_load_q <= since_load_d;
      since_add_q  <= since_add_d;
      inst_q       <= inst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      zero_q       <= zero_d;
`ifdef ISSUE_STATS_EN
      stall_q      <= stall_d;
`endif
    end
  end

  // Program memory has no reset so a loaded program survives resetn.
  always_ff @(posedge clk) begin
    if (resetn && bus.prog_we && (state_q == S_IDLE)) mem_q[bus.prog_addr] <= bus.prog_data;
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef ISSUE_STATS_EN
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: directed and randomized runs of pipe_issue against a timestamp-based issue model.
module tb_pipe_issue;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned LOAD_GAP  = 2;
  localparam int unsigned WRITE_GAP = 2;
  localparam int LDD = 1, LDC = 2, ADD = 3, MUL = 4, WR = 5;
  localparam logic [7:0] W_NOP = 8'h01, W_LDD = 8'h02, W_LDC = 8'h04;
  localparam logic [7:0] W_ADD = 8'h08, W_MUL = 8'h10, W_WR = 8'h20;

  logic clk;
  logic resetn;
  pipe_issue_if #(.DEPTH(DEPTH)) bus();
`ifdef ISSUE_STATS_EN
  logic [15:0] stall_cnt;
`endif

  pipe_issue #(.DEPTH(DEPTH), .LOAD_GAP(LOAD_GAP), .WRITE_GAP(WRITE_GAP)) dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef ISSUE_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] mem_m [DEPTH];
  logic       hp [0:511];
  logic [7:0] exp_inst [0:511];
  int         exp_t;
  int         exp_nb;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] san(input logic [7:0] w);
    logic [7:0] m;
    m = w & 8'h3F;
    return (m == 8'h00) ? W_NOP : m;
  endfunction

  // Reference: walk issue slots, remembering the slot number of the last load and last add.
  task automatic model_run(input int len);
    int t, p, last_ld, last_add;
    logic [7:0] w;
    t = 1; p = 0; last_ld = -1000; last_add = -1000; exp_nb = 0;
    while (p < len) begin
      w = san(mem_m[p]);
      if (hp[t]) begin
        exp_inst[t] = W_NOP;
      end else if ((w[MUL] && (t - last_ld) < int'(LOAD_GAP)) ||
                   (w[WR] && (t - last_add) < int'(WRITE_GAP))) begin
        exp_inst[t] = W_NOP;
        exp_nb++;
      end else begin
        exp_inst[t] = w;
        if (w[LDD] || w[LDC]) last_ld = t;
        if (w[ADD]) last_add = t;
        p++;
      end
      t++;
    end
    exp_inst[t] = W_NOP;
    exp_t = t;
  endtask

  task automatic clear_hp();
    for (int i = 0; i < 512; i++) hp[i] = 1'b0;
  endtask

  task automatic prog_write(input int addr, input logic [7:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(addr);
    bus.prog_data = data;
    @(posedge clk); #1;
    bus.prog_we   = 1'b0;
    mem_m[addr]   = data;
  endtask

  task automatic run_prog(input int len, input bit noise);
    model_run(len);
    bus.start    = 1'b1;
    bus.prog_len = 5'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("busy_e0", 32'(bus.busy), 32'(len != 0));
    check_val("inst_e0", 32'(bus.inst), 32'(W_NOP));
    for (int t = 1; t <= exp_t; t++) begin
      bus.hold = hp[t];
      if (noise && len != 0) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.prog_we   = 1'($urandom_range(0, 1));
        bus.prog_addr = 4'($urandom_range(0, 15));
        bus.prog_data = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      check_val($sformatf("inst t=%0d", t), 32'(bus.inst), 32'(exp_inst[t]));
      check_val($sformatf("done t=%0d", t), 32'(bus.done), 32'(t == exp_t));
      check_val($sformatf("busy t=%0d", t), 32'(bus.busy), 32'(t < exp_t));
    end
    bus.hold = 1'b0; bus.start = 1'b0; bus.prog_we = 1'b0;
`ifdef ISSUE_STATS_EN
    check_val("stall_cnt", 32'(stall_cnt), 32'(exp_nb));
`endif
  endtask

  task automatic run_abort(input int len, input int k);
    model_run(len);
    bus.start    = 1'b1;
    bus.prog_len = 5'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 1; t <= k; t++) begin
      @(posedge clk); #1;
      check_val($sformatf("abort inst t=%0d", t), 32'(bus.inst), 32'(exp_inst[t]));
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check_val("abort inst", 32'(bus.inst), 32'(W_NOP));
    check_val("abort busy", 32'(bus.busy), 32'd0);
    check_val("abort done", 32'(bus.done), 32'd0);
`ifdef ISSUE_STATS_EN
    check_val("abort stall", 32'(stall_cnt), 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("post-abort done", 32'(bus.done), 32'd0);
      check_val("post-abort busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.prog_len = '0; bus.start = 1'b0; bus.hold = 1'b0;
    clear_hp();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst inst", 32'(bus.inst), 32'(W_NOP));
    check_val("rst busy", 32'(bus.busy), 32'd0);
    check_val("rst done", 32'(bus.done), 32'd0);
`ifdef ISSUE_STATS_EN
    check_val("rst stall", 32'(stall_cnt), 32'd0);
`endif
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < int'(DEPTH); i++) prog_write(i, W_NOP);
    prog_write(0, W_LDD);
    prog_write(1, W_LDC);
    for (int i = 2; i < 6; i++) prog_write(i, W_ADD | W_MUL);
    prog_write(6, W_WR);

    // Normal program, then with three hold cycles from the 4th issue slot.
    run_prog(7, 1'b0);
    hp[4] = 1'b1; hp[5] = 1'b1; hp[6] = 1'b1;
    run_prog(7, 1'b0);
    clear_hp();

    // Start/write noise while busy, then an immediate back-to-back clean rerun.
    run_prog(7, 1'b1);
    run_prog(7, 1'b0);

    // Reset after the 3rd word; memory must survive for the rerun.
    run_abort(7, 3);
    run_prog(7, 1'b0);

    // Load-to-mult collision.
    prog_write(0, W_LDC);
    prog_write(1, W_LDD);
    prog_write(2, W_ADD | W_MUL);
    run_prog(3, 1'b0);

    run_prog(0, 1'b0);

    // Undefined-bit words.
    prog_write(0, 8'h00);
    prog_write(1, 8'hC0);
    prog_write(2, 8'hC8);
    prog_write(3, 8'hE0);
    run_prog(4, 1'b0);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 9) < 7) begin
        for (int i = 0; i < int'($urandom_range(1, 8)); i++)
          prog_write(int'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      clear_hp();
      if ($urandom_range(0, 1) == 1)
        for (int t = 1; t <= 60; t++) hp[t] = ($urandom_range(0, 3) == 0);
      run_prog(int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
